// File: rtl/ysyx_22041412_trap_ctrl_if.sv
// Boundary/CSR/redirect bundle between the core pipeline and the trap controller.
// master: core side (presents the boundary, consumes CSR writes and redirects).
// slave:  trap controller side.
interface ysyx_22041412_trap_ctrl_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CSR_AW = 3
);
    logic              commit_valid_i;
    logic [XLEN-1:0]   pc_i;
    logic              ecall_i;
    logic              mret_i;
    logic              irq_mtime_i;
    logic [XLEN-1:0]   csr_mstatus_i;
    logic [XLEN-1:0]   csr_mie_i;
    logic [XLEN-1:0]   csr_mtvec_i;
    logic [XLEN-1:0]   csr_mepc_i;
    logic              csr_we_o;
    logic [CSR_AW-1:0] csr_waddr_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic              redirect_valid_o;
    logic [XLEN-1:0]   redirect_pc_o;
    logic              redirect_ready_i;
    logic              stall_o;

    modport master (
        output commit_valid_i, pc_i, ecall_i, mret_i, irq_mtime_i,
        output csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
        output redirect_ready_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o,
        input  redirect_valid_o, redirect_pc_o, stall_o
    );

    modport slave (
        input  commit_valid_i, pc_i, ecall_i, mret_i, irq_mtime_i,
        input  csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
        input  redirect_ready_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o,
        output redirect_valid_o, redirect_pc_o, stall_o
    );
endinterface

// File: rtl/ysyx_22041412_trap_ctrl.sv
// Machine-mode trap controller: takes timer interrupts, ecall and mret at an
// instruction boundary, sequences the CSR updates through a single write port
// and then redirects fetch.
// Optional: define YSYX_22041412_TRAP_VECTORED_EN to enable vectored interrupt
// dispatch when mtvec[1:0] == 2'b01 (ecall always uses the base address).
module ysyx_22041412_trap_ctrl #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CSR_AW = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22041412_trap_ctrl_if.slave    bus
);

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(1);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(4);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(5);
    localparam logic [XLEN-1:0]   CAUSE_IRQ    = {1'b1, (XLEN-1)'(7)};
    localparam logic [XLEN-1:0]   CAUSE_ECALL  = XLEN'(11);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SAVE_EPC    = 3'd1,
        SAVE_CAUSE  = 3'd2,
        SAVE_STATUS = 3'd3,
        RET_STATUS  = 3'd4,
        REDIRECT    = 3'd5
    } state_t;

    state_t              state;
    logic [XLEN-1:0]     status_q;
    logic [XLEN-1:0]     cause_q;
    logic                irq_q;
    logic                mret_q;

    logic                csr_we_q;
    logic [CSR_AW-1:0]   csr_waddr_q;
    logic [XLEN-1:0]     csr_wdata_q;
    logic                redirect_valid_q;
    logic [XLEN-1:0]     redirect_pc_q;

    logic                irq_pend;
    logic                accept;
    logic                trap_sel;
    logic [XLEN-1:0]     tvec_base;
    logic [XLEN-1:0]     trap_target;
    logic [XLEN-1:0]     redirect_target;

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap return: MIE <- MPIE, MPIE <- 1.
    function automatic logic [XLEN-1:0] ret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r    = s;
        r[3] = s[7];
        r[7] = 1'b1;
        return r;
    endfunction

    // Event qualification at the boundary; interrupt beats ecall beats mret.
    always_comb begin
        irq_pend = bus.irq_mtime_i & bus.csr_mie_i[7] & bus.csr_mstatus_i[3];
        trap_sel = irq_pend | bus.ecall_i;
        accept   = (state == IDLE) & bus.commit_valid_i & (trap_sel | bus.mret_i);
    end

    // Redirect target, evaluated from the live CSR values when entering REDIRECT.
    always_comb begin
        tvec_base   = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
        trap_target = tvec_base;
`ifdef YSYX_22041412_TRAP_VECTORED_EN
        if (irq_q && (bus.csr_mtvec_i[1:0] == 2'b01)) begin
            trap_target = tvec_base + XLEN'({cause_q[5:0], 2'b00});
        end
`endif
        redirect_target = mret_q ? bus.csr_mepc_i : trap_target;
    end

    // Sequencer: state, event latches and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            status_q         <= '0;
            cause_q          <= '0;
            irq_q            <= 1'b0;
            mret_q           <= 1'b0;
            csr_we_q         <= 1'b0;
            csr_waddr_q      <= '0;
            csr_wdata_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        status_q <= bus.csr_mstatus_i;
                        irq_q    <= irq_pend;
                        csr_we_q <= 1'b1;
                        if (trap_sel) begin
                            // csr_wdata_q holds the latched epc for the mepc write
                            cause_q     <= irq_pend ? CAUSE_IRQ : CAUSE_ECALL;
                            mret_q      <= 1'b0;
                            csr_waddr_q <= ADDR_MEPC;
                            csr_wdata_q <= bus.pc_i;
                            state       <= SAVE_EPC;
                        end else begin
                            cause_q     <= '0;
                            mret_q      <= 1'b1;
                            csr_waddr_q <= ADDR_MSTATUS;
                            csr_wdata_q <= ret_mstatus(bus.csr_mstatus_i);
                            state       <= RET_STATUS;
                        end
                    end
                end
                SAVE_EPC: begin
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= ADDR_MCAUSE;
                    csr_wdata_q <= cause_q;
                    state       <= SAVE_CAUSE;
                end
                SAVE_CAUSE: begin
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= ADDR_MSTATUS;
                    csr_wdata_q <= trap_mstatus(status_q);
                    state       <= SAVE_STATUS;
                end
                SAVE_STATUS, RET_STATUS: begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= redirect_target;
                    state            <= REDIRECT;
                end
                REDIRECT: begin
                    if (bus.redirect_ready_i) begin
                        redirect_valid_q <= 1'b0;
                        redirect_pc_q    <= '0;
                        state            <= IDLE;
                    end
                end
                default: begin
                    redirect_valid_q <= 1'b0;
                    redirect_pc_q    <= '0;
                    state            <= IDLE;
                end
            endcase
        end
    end

    // Output drive; stall also covers the IDLE cycle in which an event is accepted.
    assign bus.csr_we_o         = csr_we_q;
    assign bus.csr_waddr_o      = csr_waddr_q;
    assign bus.csr_wdata_o      = csr_wdata_q;
    assign bus.redirect_valid_o = redirect_valid_q;
    assign bus.redirect_pc_o    = redirect_pc_q;
    assign bus.stall_o          = (state != IDLE) | accept;

    // Bits of the CSR inputs that this block intentionally ignores.
    logic unused_bits;
`ifdef YSYX_22041412_TRAP_VECTORED_EN
    assign unused_bits = ^{bus.csr_mie_i[XLEN-1:8], bus.csr_mie_i[6:0]};
`else
    assign unused_bits = ^{bus.csr_mie_i[XLEN-1:8], bus.csr_mie_i[6:0],
                           bus.csr_mtvec_i[1:0], irq_q};
`endif

endmodule

// File: tb/tb_ysyx_22041412_trap_ctrl.sv
// Self-checking bench for ysyx_22041412_trap_ctrl: directed scenarios followed by
// randomized boundary events, checked cycle by cycle against a transaction model.
module tb_ysyx_22041412_trap_ctrl;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CSR_AW = 3;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    ysyx_22041412_trap_ctrl_if #(.XLEN(XLEN), .CSR_AW(CSR_AW)) bus ();

    ysyx_22041412_trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: mstatus images written on trap entry / trap return.
    function automatic logic [63:0] m_trap_status(input logic [63:0] s);
        return (s & ~64'h1888) | 64'h1800 | ((s & 64'h8) << 4);
    endfunction

    function automatic logic [63:0] m_ret_status(input logic [63:0] s);
        return (s & ~64'h8) | 64'h80 | ((s & 64'h80) >> 4);
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_we"},    64'(bus.csr_we_o),         64'd0);
        check({tag, "_waddr"}, 64'(bus.csr_waddr_o),      64'd0);
        check({tag, "_wdata"}, bus.csr_wdata_o,           64'd0);
        check({tag, "_rv"},    64'(bus.redirect_valid_o), 64'd0);
        check({tag, "_rpc"},   bus.redirect_pc_o,         64'd0);
        check({tag, "_stall"}, 64'(bus.stall_o),          64'd0);
    endtask

    // Present one boundary, then follow the whole sequence against the model.
    task automatic run_event(input string tag, input logic commit, input logic irq,
                             input logic ec, input logic mr, input logic [63:0] pc,
                             input logic [63:0] st, input logic [63:0] mie,
                             input logic [63:0] tvec, input logic [63:0] mepc,
                             input int hold, input logic jitter_irq);
        int          kind;
        int          nw;
        int          rcyc;
        logic [2:0]  wa [3];
        logic [63:0] wd [3];
        logic [63:0] rpc;

        // kind: 0 none, 1 interrupt, 2 ecall, 3 mret
        kind = 0;
        if (commit) begin
            if (irq && mie[7] && st[3]) kind = 1;
            else if (ec)                kind = 2;
            else if (mr)                kind = 3;
        end
        wa = '{3'd0, 3'd0, 3'd0};
        wd = '{64'd0, 64'd0, 64'd0};
        nw = 0;
        rpc = tvec & ~64'h3;
        if (kind == 1 || kind == 2) begin
            wa[0] = 3'd4; wd[0] = pc;
            wa[1] = 3'd5; wd[1] = (kind == 1) ? 64'h8000_0000_0000_0007 : 64'hB;
            wa[2] = 3'd1; wd[2] = m_trap_status(st);
            nw = 3;
`ifdef YSYX_22041412_TRAP_VECTORED_EN
            if (kind == 1 && tvec[1:0] == 2'b01) rpc = rpc + 64'h1C;
`endif
        end else if (kind == 3) begin
            wa[0] = 3'd1; wd[0] = m_ret_status(st);
            nw = 1;
            rpc = mepc;
        end
        rcyc = nw + 1;

        @(negedge clk);
        bus.commit_valid_i   = commit;
        bus.irq_mtime_i      = irq;
        bus.ecall_i          = ec;
        bus.mret_i           = mr;
        bus.pc_i             = pc;
        bus.csr_mstatus_i    = st;
        bus.csr_mie_i        = mie;
        bus.csr_mtvec_i      = tvec;
        bus.csr_mepc_i       = mepc;
        bus.redirect_ready_i = 1'b0;
        #1;
        check({tag, "_accept_stall"}, 64'(bus.stall_o), 64'(kind != 0));
        @(posedge clk);
        #1;
        bus.commit_valid_i = 1'b0;
        bus.ecall_i        = 1'b0;
        bus.mret_i         = 1'b0;
        if (kind == 0) begin
            check_quiet({tag, "_none"});
            return;
        end
        for (int k = 1; k <= rcyc + hold + 1; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (jitter_irq) bus.irq_mtime_i = 1'($urandom_range(0, 1));
            check({tag, "_we"},    64'(bus.csr_we_o),    64'(k <= nw));
            check({tag, "_waddr"}, 64'(bus.csr_waddr_o), (k <= nw) ? 64'(wa[k-1]) : 64'd0);
            check({tag, "_wdata"}, bus.csr_wdata_o,      (k <= nw) ? wd[k-1] : 64'd0);
            check({tag, "_rv"},    64'(bus.redirect_valid_o), 64'(k >= rcyc && k <= rcyc + hold));
            if (k >= rcyc && k <= rcyc + hold)
                check({tag, "_rpc"}, bus.redirect_pc_o, rpc);
            check({tag, "_stall"}, 64'(bus.stall_o), 64'(k <= rcyc + hold));
            bus.redirect_ready_i = (k == rcyc + hold) ? 1'b1 : 1'b0;
        end
        bus.redirect_ready_i = 1'b0;
        bus.irq_mtime_i      = 1'b0;
    endtask

    initial begin
        logic [63:0] r_pc, r_st, r_mie, r_tvec, r_mepc;
        logic        r_commit;

        bus.commit_valid_i   = 1'b0;
        bus.pc_i             = '0;
        bus.ecall_i          = 1'b0;
        bus.mret_i           = 1'b0;
        bus.irq_mtime_i      = 1'b0;
        bus.csr_mstatus_i    = '0;
        bus.csr_mie_i        = '0;
        bus.csr_mtvec_i      = '0;
        bus.csr_mepc_i       = '0;
        bus.redirect_ready_i = 1'b0;

        // Reset values with no clock edge required.
        rst_n = 1'b0;
        #1;
        check_quiet("reset");
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        run_event("ecall", 1, 0, 1, 0, 64'h8000_0010, 64'h0, 64'h0,
                  64'h8000_1000, 64'h0, 0, 0);
        run_event("irq", 1, 1, 0, 0, 64'h8000_0200, 64'h8, 64'h80,
                  64'h8000_1000, 64'h0, 1, 1);
        run_event("irq_and_ecall", 1, 1, 1, 0, 64'h8000_0300, 64'h8, 64'h80,
                  64'h8000_2001, 64'h0, 0, 0);
        run_event("mret", 1, 0, 0, 1, 64'h8000_0400, 64'h80, 64'h0,
                  64'h8000_1000, 64'h8000_0014, 0, 0);
        run_event("ready_hold", 1, 0, 1, 0, 64'h8000_0500, 64'h1808, 64'h80,
                  64'h8000_3000, 64'h0, 5, 0);
        run_event("irq_masked", 1, 1, 1, 0, 64'h8000_0600, 64'h0, 64'h80,
                  64'h8000_1000, 64'h0, 0, 0);
        run_event("ecall_over_mret", 1, 0, 1, 1, 64'h8000_0700, 64'h88, 64'h0,
                  64'h8000_1000, 64'h8000_0044, 0, 0);
        run_event("no_commit", 0, 1, 1, 1, 64'h8000_0800, 64'h8, 64'h80,
                  64'h8000_1000, 64'h0, 0, 0);
        run_event("vec_mode_irq", 1, 1, 0, 0, 64'h8000_0900, 64'h8, 64'h80,
                  64'h8000_4001, 64'h0, 0, 0);

        // Reset during SAVE_CAUSE aborts the sequence before the mstatus write.
        @(negedge clk);
        bus.commit_valid_i = 1'b1;
        bus.ecall_i        = 1'b1;
        bus.pc_i           = 64'h8000_0A00;
        bus.csr_mtvec_i    = 64'h8000_1000;
        bus.csr_mstatus_i  = 64'h8;
        @(posedge clk);
        #1;
        bus.commit_valid_i = 1'b0;
        bus.ecall_i        = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_cause_waddr", 64'(bus.csr_waddr_o), 64'd5);
        rst_n = 1'b0;
        #1;
        check_quiet("abort_async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_quiet("abort_after");
        end

        // Randomized boundaries.
        for (int n = 0; n < 40; n++) begin
            r_pc     = {$urandom, $urandom} & ~64'h3;
            r_st     = {$urandom, $urandom};
            r_mie    = {$urandom, $urandom};
            r_tvec   = {$urandom, $urandom};
            r_mepc   = {$urandom, $urandom};
            r_commit = ($urandom_range(0, 9) != 0);
            run_event("rand", r_commit, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), r_pc, r_st, r_mie, r_tvec, r_mepc,
                      int'($urandom_range(0, 3)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ysyx_22041412_trap_ctrl.md
YSYX_22041412_TRAP_CTRL -- requirements
Module: ysyx_22041412_trap_ctrl

Interface
REQ-001 SHALL declare parameter XLEN, default 64, data/PC width.
REQ-002 SHALL declare parameter CSR_AW, default 3, CSR index width (mstatus=1, mie=2, mtvec=3, mepc=4, mcause=5, mip=6).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port commit_valid_i  input  1  instruction boundary; pc_i is valid and that instruction has not yet retired.
REQ-006 SHALL have port pc_i  input  XLEN  PC of the instruction at the boundary.
REQ-007 SHALL have ports ecall_i, mret_i  input  1 each  boundary instruction is ecall or mret; qualified by commit_valid_i.
REQ-008 SHALL have port irq_mtime_i  input  1  level timer-interrupt request.
REQ-009 SHALL have ports csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i  input  XLEN each  current CSR values.
REQ-010 SHALL have ports csr_we_o (1), csr_waddr_o (CSR_AW), csr_wdata_o (XLEN)  output  single CSR write port.
REQ-011 SHALL have ports redirect_valid_o (1), redirect_pc_o (XLEN)  output  fetch redirect; redirect_ready_i  input  1  accept.
REQ-012 SHALL have port stall_o  output  1  core holds its boundary while high.

Function
REQ-013 SHALL implement FSM states IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, RET_STATUS, REDIRECT.
REQ-014 SHALL treat an interrupt as pending when irq_mtime_i & csr_mie_i[7] & csr_mstatus_i[3].
REQ-015 In IDLE with commit_valid_i, SHALL select by priority: pending interrupt > ecall_i > mret_i; a lower-priority event in the same cycle is dropped, and the core re-presents it.
REQ-016 On trap selection, SHALL latch pc_i as epc, latch cause (0x8000000000000007 for interrupt, 0xB for ecall), latch csr_mstatus_i, then go to SAVE_EPC.
REQ-017 On mret selection, SHALL latch csr_mstatus_i and go to RET_STATUS.
REQ-018 SAVE_EPC, SAVE_CAUSE and SAVE_STATUS SHALL each last exactly one cycle, asserting csr_we_o with address mepc, mcause and mstatus respectively, in that order.
REQ-019 Trap mstatus write SHALL be: bit7 (MPIE) set to latched bit3, bit3 (MIE) set to 0, bits[12:11] (MPP) set to 2'b11, all other bits kept.
REQ-020 RET_STATUS SHALL write mstatus for one cycle: bit3 set to latched bit7, bit7 set to 1, all other bits kept; then go to REDIRECT.
REQ-021 REDIRECT SHALL hold redirect_valid_o=1 with a stable redirect_pc_o until redirect_ready_i=1, then return to IDLE on the next edge.
REQ-022 Trap redirect_pc_o SHALL be {csr_mtvec_i[XLEN-1:2],2'b00}, sampled in REDIRECT; mret redirect_pc_o SHALL be csr_mepc_i sampled in REDIRECT.
REQ-023 Latency: trap = 1 accept cycle + 3 write cycles, so redirect_valid_o rises 4 cycles after acceptance; mret rises 2 cycles after acceptance.
REQ-024 stall_o SHALL be high in every state except IDLE; it SHALL also be high combinationally in the IDLE acceptance cycle.
REQ-025 csr_we_o SHALL be 0 in IDLE and REDIRECT; csr_waddr_o and csr_wdata_o SHALL be 0 whenever csr_we_o=0.
REQ-026 irq_mtime_i changes after acceptance SHALL NOT alter an in-flight sequence.

Reset
REQ-027 While rst=0, SHALL force state IDLE and all outputs and latches to 0 immediately, with no clock required.
REQ-028 Reset asserted mid-sequence SHALL abort it; no further CSR writes occur after reset is released until a new acceptance.

Configuration
REQ-029 With macro YSYX_22041412_TRAP_VECTORED_EN defined and csr_mtvec_i[1:0]==2'b01, interrupt redirect SHALL be base + 4*cause[5:0] (base+0x1C for mtime).
REQ-030 Ecall SHALL always use the base address; without the macro, all traps SHALL use the base address regardless of mtvec[1:0].

Verification
REQ-031 ecall at pc_i=0x80000010, mtvec=0x80001000 -> writes mepc=0x80000010, then mcause=0xB, then mstatus; redirect 0x80001000 on cycle 4.
REQ-032 irq_mtime_i=1, mie[7]=1, mstatus=0x8 -> mcause=0x8000000000000007 written, mstatus written with bit3=0, bit7=1, bits[12:11]=11.
REQ-033 Interrupt and ecall presented in the same cycle -> interrupt cause taken; epc = pc_i of the ecall.
REQ-034 mret with mstatus=0x80, mepc=0x80000014 -> mstatus write sets bit3=1, bit7=1; redirect 0x80000014 on cycle 2.
REQ-035 redirect_ready_i held 0 for 5 cycles -> redirect_valid_o and redirect_pc_o stay stable and stall_o stays 1.
REQ-036 rst driven low during SAVE_CAUSE -> outputs go to 0 at once, state returns to IDLE, and the mstatus write never occurs.
